// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: qualifies guesses, grants big shots,
// accumulates score and ship mask, and declares win or loss.
module battleship_game_ctrl #(
    parameter int         MAX_MOVES = 20,
    parameter int         NUM_BIG   = 2,
    parameter logic [4:0] WIN_MASK  = 5'b1_1111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       StartGame,
    input  logic       Guess,
    input  logic [3:0] GuessX,
    input  logic [3:0] GuessY,
    input  logic       BigReq,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       Big,
    output logic       ScoreThis,
    input  logic [3:0] NumHits,
    input  logic [4:0] BiggestShipHit,
    output logic [6:0] TotalHits,
    output logic [4:0] ShipsHit,
    output logic [4:0] MovesLeft,
    output logic [2:0] BigLeft,
    output logic       BadGuess,
    output logic       GameOver,
    output logic       GameWon
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    state_t     state;
    logic       valid_xy;
    logic [7:0] hits_sum;
    logic [6:0] hits_sat;
    logic [4:0] ships_next;

    assign X         = GuessX;
    assign Y         = GuessY;
    assign valid_xy  = (GuessX >= 4'd1) && (GuessX <= 4'd10) &&
                       (GuessY >= 4'd1) && (GuessY <= 4'd10);
    assign ScoreThis = (state == PLAY) && Guess && valid_xy;
    assign Big       = ScoreThis && BigReq && (BigLeft != 3'd0);

    assign hits_sum   = {1'b0, TotalHits} + {4'b0000, NumHits};
    assign hits_sat   = hits_sum[7] ? 7'h7f : hits_sum[6:0];
    assign ships_next = ShipsHit | BiggestShipHit;

    // StartGame outranks any guess in the same cycle, whatever the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            TotalHits <= '0;
            ShipsHit  <= '0;
            MovesLeft <= '0;
            BigLeft   <= '0;
            BadGuess  <= 1'b0;
            GameOver  <= 1'b0;
            GameWon   <= 1'b0;
        end else begin
            BadGuess <= 1'b0;
            if (StartGame) begin
                state     <= PLAY;
                MovesLeft <= 5'(MAX_MOVES);
                BigLeft   <= 3'(NUM_BIG);
                TotalHits <= '0;
                ShipsHit  <= '0;
                GameOver  <= 1'b0;
                GameWon   <= 1'b0;
            end else if (state == PLAY && Guess) begin
                if (valid_xy) begin
                    MovesLeft <= MovesLeft - 5'd1;
                    TotalHits <= hits_sat;
                    ShipsHit  <= ships_next;
                    if (Big) begin
                        BigLeft <= BigLeft - 3'd1;
                    end
                    if (ships_next == WIN_MASK) begin
                        state    <= DONE;
                        GameOver <= 1'b1;
                        GameWon  <= 1'b1;
                    end else if (MovesLeft == 5'd1) begin
                        state    <= DONE;
                        GameOver <= 1'b1;
                    end
                end else begin
                    BadGuess <= 1'b1;
                end
            end
        end
    end

endmodule
